rom_dma_batch_sched: RTL and testbench
======================================

# rom_dma_batch_sched

Batch scheduler directly upstream of the ROM DMA controller. Holds a small table of (base address, byte count) entries and drives the controller's configuration/start inputs one batch at a time. Each following batch issues only after the previous DMA reports done and the request FIFO/linked-list interface has drained. Replaces the free-running heartbeat start so software or a testbench can sequence multiple ROM regions.

## Interface
- ROM_ADDR_WIDTH, 10, ROM address / byte-count width
- NUM_BATCHES, 4, table depth (≥2); IDX_W = $clog2(NUM_BATCHES)
- DRAIN_CYCLES, 4, consecutive idle cycles required to declare drain (≥1)
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- tbl_wr_en  in  1  write table entry this cycle
- tbl_wr_idx  in  IDX_W  entry index
- tbl_wr_base  in  ROM_ADDR_WIDTH  entry base address
- tbl_wr_len  in  ROM_ADDR_WIDTH  entry byte count
- tbl_num_vld  in  IDX_W+1  number of valid entries, sampled on go
- go  in  1  start pulse
- stop  in  1  finish current batch, then end
- start_rd  out  1  DMA start to controller
- cfg_ready  out  1  configuration valid to controller
- cfg_dma_base_addr  out  ROM_ADDR_WIDTH  batch base
- cfg_dma_num_bytes  out  ROM_ADDR_WIDTH  batch length (clipped)
- batch_dma_done  in  1  controller done pulse
- fifo_empty  in  1  ROM data FIFO empty
- intf_ready  in  1  linked-list interface idle
- sched_busy  out  1  schedule in progress
- sched_done  out  1  one-cycle pulse at schedule end
- batch_idx  out  IDX_W  index of current batch
- tbl_wr_err  out  1  one-cycle pulse: write while busy (write dropped)

## Operation
- States: IDLE, LOAD, ISSUE, WAIT_DMA, DRAIN, NEXT, DONE.
- IDLE: table writable. go with tbl_num_vld≠0 → LOAD, idx=0, latch count (values >NUM_BATCHES saturate to NUM_BATCHES). go with tbl_num_vld=0 → DONE directly.
- LOAD: cfg_dma_base_addr←base[idx]; cfg_dma_num_bytes←min(len, 2^ROM_ADDR_WIDTH − base), computed at ROM_ADDR_WIDTH+1 bits. If clipped length is 0 → NEXT (no DMA issued); else → ISSUE.
- ISSUE: start_rd=1, cfg_ready=1 → WAIT_DMA. Both stay 1 through WAIT_DMA.
- WAIT_DMA: on batch_dma_done, drop start_rd/cfg_ready next cycle → DRAIN, clear drain counter.
- DRAIN: counter increments while fifo_empty&&intf_ready, clears to 0 otherwise; reaching DRAIN_CYCLES → NEXT.
- NEXT: if stop latched or idx==count−1 → DONE; else idx+1 → LOAD.
- DONE: sched_done=1 one cycle → IDLE.
- stop: sticky latch set in any non-IDLE state, cleared in IDLE; never aborts an issued DMA.
- go while not IDLE: ignored. tbl_wr_en while not IDLE: entry unchanged, tbl_wr_err pulses.
- Simultaneous tbl_wr_en and go in IDLE: write takes effect; the schedule uses the new value.
- sched_busy=1 in every state except IDLE.

## Timing
- Reset values: start_rd=0, cfg_ready=0, cfg_dma_base_addr=0, cfg_dma_num_bytes=0, sched_busy=0, sched_done=0, batch_idx=0, tbl_wr_err=0; table entries=0; state=IDLE.
- All outputs are registered.
- go (cycle 0) → cfg valid cycle 2 → start_rd/cfg_ready high cycle 3.
- batch_dma_done at cycle t → start_rd low at t+1.
- Minimum batch-to-batch gap after done: 1 + DRAIN_CYCLES + 2 cycles.
- Reset mid-schedule: all state returns to reset values on the next edge; no further start_rd.
- batch_dma_done outside WAIT_DMA: ignored.

## Configuration
- SCHED_LOOP_EN defined: in NEXT with idx==count−1 and no stop, idx wraps to 0 → LOAD, so the schedule repeats until stop; sched_done pulses only on stop exit.
- SCHED_LOOP_EN undefined: a single pass; stop only shortens it.

## Structure
- rom_dma_pkg: t_sched_state enum, t_batch_entry packed struct {base, len}, SCHED_NUM_BATCHES default constant.
- Sub-module sched_batch_table: NUM_BATCHES×t_batch_entry register file with write-enable and write-protect input (busy), combinational read by idx.

## Test plan
- Table {0:(0,16), 1:(32,8)}, num_vld=2, go; controller model returns done 20 cycles after start → two start_rd windows with base/len 0/16 then 32/8, sched_done once, batch_idx 0→1.
- Entry (1020,10), ROM_ADDR_WIDTH=10 → cfg_dma_num_bytes=4.
- Entry 1 len=0 among three entries → only two start_rd assertions; idx passes 0,1,2.
- Hold fifo_empty low for 10 cycles after done → next ISSUE delayed until 4 consecutive idle cycles; toggling idle at cycle 2 restarts the count.
- tbl_wr_en during WAIT_DMA → tbl_wr_err pulse, entry unchanged. go while busy → no effect.
- stop during batch 0 of 3 → batch 0 completes, no batch 1, sched_done. With SCHED_LOOP_EN and no stop → idx wraps 1→0 and repeats. Reset in WAIT_DMA → outputs at reset values next cycle.

Source files
------------

// File: rtl/rom_dma_batch_sched_pkg.sv
// Shared types for the ROM DMA batch scheduler: FSM state encoding and table entry layout.
package rom_dma_pkg;

  localparam int unsigned SCHED_NUM_BATCHES    = 4;
  localparam int unsigned SCHED_ROM_ADDR_WIDTH = 10;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StIssue,
    StWaitDma,
    StDrain,
    StNext,
    StDone
  } t_sched_state;

  typedef struct packed {
    logic [SCHED_ROM_ADDR_WIDTH-1:0] base;
    logic [SCHED_ROM_ADDR_WIDTH-1:0] len;
  } t_batch_entry;

endpackage

// File: rtl/rom_dma_batch_sched_if.sv
// Scheduler <-> ROM DMA controller link: batch configuration/start out, completion and idle status in.
interface rom_dma_batch_sched_if #(
  parameter int unsigned ROM_ADDR_WIDTH = 10
);

  logic                      start_rd;
  logic                      cfg_ready;
  logic [ROM_ADDR_WIDTH-1:0] cfg_dma_base_addr;
  logic [ROM_ADDR_WIDTH-1:0] cfg_dma_num_bytes;
  logic                      batch_dma_done;
  logic                      fifo_empty;
  logic                      intf_ready;

  modport master (
    output start_rd,
    output cfg_ready,
    output cfg_dma_base_addr,
    output cfg_dma_num_bytes,
    input  batch_dma_done,
    input  fifo_empty,
    input  intf_ready
  );

  modport slave (
    input  start_rd,
    input  cfg_ready,
    input  cfg_dma_base_addr,
    input  cfg_dma_num_bytes,
    output batch_dma_done,
    output fifo_empty,
    output intf_ready
  );

endinterface

// File: rtl/rom_dma_batch_sched_table.sv
// Batch table register file: one write port gated by a write-protect, combinational read by index.
module sched_batch_table
  import rom_dma_pkg::*;
#(
  parameter int unsigned NUM_BATCHES = SCHED_NUM_BATCHES,
  localparam int unsigned IDX_W = $clog2(NUM_BATCHES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic             wr_protect,
  input  logic [IDX_W-1:0] wr_idx,
  input  t_batch_entry     wr_entry,
  input  logic [IDX_W-1:0] rd_idx,
  output t_batch_entry     rd_entry
);

  // Sized to the full index space so any index value addresses storage.
  t_batch_entry entries [2**IDX_W];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2**IDX_W; i++) begin
        entries[i] <= '0;
      end
    end else if (wr_en && !wr_protect) begin
      entries[wr_idx] <= wr_entry;
    end
  end

  assign rd_entry = entries[rd_idx];

endmodule

// File: rtl/rom_dma_batch_sched.sv
// Sequences ROM DMA batches from a small table, waiting for done plus a drain window between batches.
// Optional macro SCHED_LOOP_EN: repeat the table until stop instead of a single pass.
module rom_dma_batch_sched
  import rom_dma_pkg::*;
#(
  parameter int unsigned ROM_ADDR_WIDTH = SCHED_ROM_ADDR_WIDTH,
  parameter int unsigned NUM_BATCHES    = SCHED_NUM_BATCHES,
  parameter int unsigned DRAIN_CYCLES   = 4,
  localparam int unsigned IDX_W = $clog2(NUM_BATCHES)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      tbl_wr_en,
  input  logic [IDX_W-1:0]          tbl_wr_idx,
  input  logic [ROM_ADDR_WIDTH-1:0] tbl_wr_base,
  input  logic [ROM_ADDR_WIDTH-1:0] tbl_wr_len,
  input  logic [IDX_W:0]            tbl_num_vld,
  input  logic                      go,
  input  logic                      stop,
  rom_dma_batch_sched_if.master     dma,
  output logic                      sched_busy,
  output logic                      sched_done,
  output logic [IDX_W-1:0]          batch_idx,
  output logic                      tbl_wr_err
);

  localparam int unsigned CNT_W = $clog2(DRAIN_CYCLES + 1);
  localparam logic [ROM_ADDR_WIDTH:0] ROM_SPAN = {1'b1, {ROM_ADDR_WIDTH{1'b0}}};

  t_sched_state         state;
  logic                 stop_q;
  logic [IDX_W:0]       count_q;
  logic [CNT_W-1:0]     drain_cnt;
  t_batch_entry         wr_entry;
  t_batch_entry         rd_entry;
  logic [ROM_ADDR_WIDTH:0]   room;
  logic [ROM_ADDR_WIDTH-1:0] clip_bytes;
  logic [IDX_W:0]       num_sat;
  logic                 last_idx;

  assign wr_entry = '{base: tbl_wr_base, len: tbl_wr_len};

  sched_batch_table #(
    .NUM_BATCHES (NUM_BATCHES)
  ) u_table (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (tbl_wr_en),
    .wr_protect (state != StIdle),
    .wr_idx     (tbl_wr_idx),
    .wr_entry   (wr_entry),
    .rd_idx     (batch_idx),
    .rd_entry   (rd_entry)
  );

  // Clip so a batch never runs past the top of the ROM; one extra bit holds the full span.
  always_comb begin
    room       = ROM_SPAN - {1'b0, rd_entry.base};
    clip_bytes = rd_entry.len;
    if ({1'b0, rd_entry.len} > room) begin
      clip_bytes = room[ROM_ADDR_WIDTH-1:0];
    end
  end

  assign num_sat  = (tbl_num_vld > (IDX_W+1)'(NUM_BATCHES)) ? (IDX_W+1)'(NUM_BATCHES) : tbl_num_vld;
  assign last_idx = ({1'b0, batch_idx} == (count_q - (IDX_W+1)'(1)));

  always_ff @(posedge clk) begin
    if (reset) begin
      state                 <= StIdle;
      stop_q                <= 1'b0;
      count_q               <= '0;
      drain_cnt             <= '0;
      dma.start_rd          <= 1'b0;
      dma.cfg_ready         <= 1'b0;
      dma.cfg_dma_base_addr <= '0;
      dma.cfg_dma_num_bytes <= '0;
      sched_busy            <= 1'b0;
      sched_done            <= 1'b0;
      batch_idx             <= '0;
      tbl_wr_err            <= 1'b0;
    end else begin
      sched_done <= 1'b0;
      tbl_wr_err <= tbl_wr_en && (state != StIdle);
      if (state == StIdle) begin
        stop_q <= 1'b0;
      end else if (stop) begin
        stop_q <= 1'b1;
      end

      unique case (state)
        StIdle: begin
          if (go) begin
            sched_busy <= 1'b1;
            if (tbl_num_vld == '0) begin
              sched_done <= 1'b1;
              state      <= StDone;
            end else begin
              batch_idx <= '0;
              count_q   <= num_sat;
              state     <= StLoad;
            end
          end
        end
        StLoad: begin
          dma.cfg_dma_base_addr <= rd_entry.base;
          dma.cfg_dma_num_bytes <= clip_bytes;
          state <= (clip_bytes == '0) ? StNext : StIssue;
        end
        StIssue: begin
          dma.start_rd  <= 1'b1;
          dma.cfg_ready <= 1'b1;
          state         <= StWaitDma;
        end
        StWaitDma: begin
          if (dma.batch_dma_done) begin
            dma.start_rd  <= 1'b0;
            dma.cfg_ready <= 1'b0;
            drain_cnt     <= '0;
            state         <= StDrain;
          end
        end
        StDrain: begin
          if (dma.fifo_empty && dma.intf_ready) begin
            if (drain_cnt == CNT_W'(DRAIN_CYCLES - 1)) begin
              state <= StNext;
            end else begin
              drain_cnt <= drain_cnt + CNT_W'(1);
            end
          end else begin
            drain_cnt <= '0;
          end
        end
        StNext: begin
          if (stop_q || stop) begin
            sched_done <= 1'b1;
            state      <= StDone;
          end else if (last_idx) begin
`ifdef SCHED_LOOP_EN
            batch_idx <= '0;
            state     <= StLoad;
`else
            sched_done <= 1'b1;
            state      <= StDone;
`endif
          end else begin
            batch_idx <= batch_idx + IDX_W'(1);
            state     <= StLoad;
          end
        end
        StDone: begin
          sched_busy <= 1'b0;
          state      <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_dma_batch_sched.sv
// Directed bench for rom_dma_batch_sched (default single-pass build, 10-bit ROM, 4 entries, 4 drain cycles).
module tb_rom_dma_batch_sched;

  localparam int unsigned W     = 10;
  localparam int unsigned NB    = 4;
  localparam int unsigned IDX_W = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             tbl_wr_en;
  logic [IDX_W-1:0] tbl_wr_idx;
  logic [W-1:0]     tbl_wr_base;
  logic [W-1:0]     tbl_wr_len;
  logic [IDX_W:0]   tbl_num_vld;
  logic             go;
  logic             stop;
  logic             sched_busy;
  logic             sched_done;
  logic [IDX_W-1:0] batch_idx;
  logic             tbl_wr_err;

  int errs   = 0;
  int checks = 0;
  int starts, mask, dones, lb, ll;

  rom_dma_batch_sched_if #(.ROM_ADDR_WIDTH(W)) dma ();

  rom_dma_batch_sched #(
    .ROM_ADDR_WIDTH (W),
    .NUM_BATCHES    (NB),
    .DRAIN_CYCLES   (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .tbl_wr_en   (tbl_wr_en),
    .tbl_wr_idx  (tbl_wr_idx),
    .tbl_wr_base (tbl_wr_base),
    .tbl_wr_len  (tbl_wr_len),
    .tbl_num_vld (tbl_num_vld),
    .go          (go),
    .stop        (stop),
    .dma         (dma),
    .sched_busy  (sched_busy),
    .sched_done  (sched_done),
    .batch_idx   (batch_idx),
    .tbl_wr_err  (tbl_wr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int idx, input int base, input int len);
    tbl_wr_en   = 1'b1;
    tbl_wr_idx  = IDX_W'(idx);
    tbl_wr_base = W'(base);
    tbl_wr_len  = W'(len);
    tick;
    tbl_wr_en = 1'b0;
  endtask

  task automatic go_pulse(input int num);
    tbl_num_vld = (IDX_W+1)'(num);
    go = 1'b1;
    tick;
    go = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_start_rd"}, 32'(dma.start_rd), 0);
    chk({tag, "_cfg_ready"}, 32'(dma.cfg_ready), 0);
    chk({tag, "_base"}, 32'(dma.cfg_dma_base_addr), 0);
    chk({tag, "_bytes"}, 32'(dma.cfg_dma_num_bytes), 0);
    chk({tag, "_busy"}, 32'(sched_busy), 0);
    chk({tag, "_done"}, 32'(sched_done), 0);
    chk({tag, "_idx"}, 32'(batch_idx), 0);
    chk({tag, "_wr_err"}, 32'(tbl_wr_err), 0);
  endtask

  // Controller model: pulses done once start_rd has been high for dly cycles; runs until sched_done.
  task automatic run_sched(input int max_cyc, input int dly, output int n_start, output int idx_mask,
                           output int n_done, output int last_base, output int last_len);
    int hi  = 0;
    bit fin = 1'b0;
    n_start = 0; idx_mask = 0; n_done = 0; last_base = -1; last_len = -1;
    for (int c = 0; c < max_cyc && !fin; c++) begin
      tick;
      if (dma.start_rd) hi++; else hi = 0;
      if (dma.start_rd && hi == 1) begin
        n_start++;
        last_base = int'(dma.cfg_dma_base_addr);
        last_len  = int'(dma.cfg_dma_num_bytes);
      end
      if (sched_busy) idx_mask |= (1 << batch_idx);
      if (sched_done) begin
        n_done++;
        fin = 1'b1;
      end
      dma.batch_dma_done = (hi == dly);
    end
    dma.batch_dma_done = 1'b0;
    chk("sched_finished_in_budget", 32'(fin), 1);
    tick;
  endtask

  initial begin
    reset = 1'b1; tbl_wr_en = 1'b0; tbl_wr_idx = '0; tbl_wr_base = '0; tbl_wr_len = '0;
    tbl_num_vld = '0; go = 1'b0; stop = 1'b0;
    dma.batch_dma_done = 1'b0; dma.fifo_empty = 1'b1; dma.intf_ready = 1'b1;
    tick; tick;
    chk_reset_vals("rst");
    reset = 1'b0;

    // Two-batch schedule with exact latencies, write-while-busy, go-while-busy, drain restart.
    wr(0, 0, 16);
    wr(1, 32, 8);
    go_pulse(2);
    chk("t1_busy_after_go", 32'(sched_busy), 1);
    tick;
    chk("t1_cfg_base0", 32'(dma.cfg_dma_base_addr), 0);
    chk("t1_cfg_len0", 32'(dma.cfg_dma_num_bytes), 16);
    chk("t1_start_not_yet", 32'(dma.start_rd), 0);
    tick;
    chk("t1_start_rd", 32'(dma.start_rd), 1);
    chk("t1_cfg_ready", 32'(dma.cfg_ready), 1);
    chk("t1_idx0", 32'(batch_idx), 0);
    tbl_wr_en = 1'b1; tbl_wr_idx = 2'd0; tbl_wr_base = 10'd500; tbl_wr_len = 10'd7; go = 1'b1;
    tick;
    tbl_wr_en = 1'b0; go = 1'b0;
    chk("t1_wr_err_pulse", 32'(tbl_wr_err), 1);
    chk("t1_start_held", 32'(dma.start_rd), 1);
    tick;
    chk("t1_wr_err_clear", 32'(tbl_wr_err), 0);
    repeat (3) tick;
    dma.batch_dma_done = 1'b1;
    tick;
    dma.batch_dma_done = 1'b0;
    chk("t1_start_drop", 32'(dma.start_rd), 0);
    chk("t1_cfg_ready_drop", 32'(dma.cfg_ready), 0);
    dma.fifo_empty = 1'b0;
    repeat (10) tick;
    chk("t1_blocked_by_fifo", 32'(dma.start_rd), 0);
    dma.fifo_empty = 1'b1;
    tick; tick;
    dma.fifo_empty = 1'b0;
    tick;
    dma.fifo_empty = 1'b1;
    repeat (6) tick;
    chk("t1_restart_no_start", 32'(dma.start_rd), 0);
    chk("t1_cfg_base1", 32'(dma.cfg_dma_base_addr), 32);
    chk("t1_cfg_len1", 32'(dma.cfg_dma_num_bytes), 8);
    chk("t1_idx1", 32'(batch_idx), 1);
    tick;
    chk("t1_start_batch1", 32'(dma.start_rd), 1);
    dma.batch_dma_done = 1'b1;
    tick;
    dma.batch_dma_done = 1'b0;
    repeat (4) tick;
    chk("t1_no_done_early", 32'(sched_done), 0);
    tick;
    chk("t1_sched_done", 32'(sched_done), 1);
    chk("t1_busy_in_done", 32'(sched_busy), 1);
    tick;
    chk("t1_done_one_cycle", 32'(sched_done), 0);
    chk("t1_idle_busy", 32'(sched_busy), 0);

    // Entry 0 must still be (0,16) after the dropped write.
    go_pulse(1);
    tick;
    chk("t1_entry_kept_base", 32'(dma.cfg_dma_base_addr), 0);
    chk("t1_entry_kept_len", 32'(dma.cfg_dma_num_bytes), 16);
    run_sched(200, 3, starts, mask, dones, lb, ll);
    chk("t1b_starts", 32'(starts), 1);

    // Clip at top of ROM, with a write in the same cycle as go.
    tbl_wr_en = 1'b1; tbl_wr_idx = 2'd0; tbl_wr_base = 10'd1020; tbl_wr_len = 10'd10;
    go_pulse(1);
    tbl_wr_en = 1'b0;
    tick;
    chk("t2_clip_base", 32'(dma.cfg_dma_base_addr), 1020);
    chk("t2_clip_len", 32'(dma.cfg_dma_num_bytes), 4);
    run_sched(200, 2, starts, mask, dones, lb, ll);
    chk("t2_starts", 32'(starts), 1);

    // Zero valid entries: straight to done.
    go_pulse(0);
    chk("t3_zero_done", 32'(sched_done), 1);
    chk("t3_zero_busy", 32'(sched_busy), 1);
    tick;
    chk("t3_zero_done_clear", 32'(sched_done), 0);
    chk("t3_zero_idle", 32'(sched_busy), 0);
    chk("t3_zero_no_start", 32'(dma.start_rd), 0);

    // Zero-length middle entry is skipped without a DMA.
    wr(0, 0, 16);
    wr(1, 64, 0);
    wr(2, 200, 5);
    go_pulse(3);
    run_sched(300, 4, starts, mask, dones, lb, ll);
    chk("t4_starts", 32'(starts), 2);
    chk("t4_idx_mask", 32'(mask), 7);
    chk("t4_last_base", 32'(lb), 200);
    chk("t4_last_len", 32'(ll), 5);
    chk("t4_dones", 32'(dones), 1);

    // Stop during batch 0 of 3.
    wr(1, 32, 8);
    go_pulse(3);
    stop = 1'b1;
    tick;
    stop = 1'b0;
    run_sched(300, 5, starts, mask, dones, lb, ll);
    chk("t5_stop_starts", 32'(starts), 1);
    chk("t5_stop_mask", 32'(mask), 1);
    chk("t5_stop_len", 32'(ll), 16);
    chk("t5_stop_dones", 32'(dones), 1);

    // Count above table depth saturates to 4 entries.
    wr(3, 1000, 30);
    go_pulse(7);
    run_sched(400, 2, starts, mask, dones, lb, ll);
    chk("t6_sat_starts", 32'(starts), 4);
    chk("t6_sat_mask", 32'(mask), 15);
    chk("t6_sat_last_base", 32'(lb), 1000);
    chk("t6_sat_last_len", 32'(ll), 24);

    // Reset while waiting on the DMA; table is cleared too.
    go_pulse(2);
    tick; tick;
    chk("t7_start_before_rst", 32'(dma.start_rd), 1);
    tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk_reset_vals("t7_rst");
    repeat (5) tick;
    chk("t7_no_start_after_rst", 32'(dma.start_rd), 0);
    go_pulse(1);
    run_sched(100, 2, starts, mask, dones, lb, ll);
    chk("t7_cleared_table_starts", 32'(starts), 0);
    chk("t7_cleared_table_dones", 32'(dones), 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
